noc_credit_tx: RTL and testbench
================================

NOC_CREDIT_TX -- requirements
Module: noc_credit_tx

Interface
REQ-001 Parameter: FLIT_WIDTH, default 256, flit payload width in bits.
REQ-002 Parameter: DEST_WIDTH, default 4, destination endpoint ID width.
REQ-003 Parameter: FLIT_BUFFER_DEPTH, default 2, downstream router input buffer depth in flits; initial credit count; legal range 1..255.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-006 Port: in_valid  input  1  upstream flit valid.
REQ-007 Port: in_ready  output  1  block accepts the upstream flit this cycle.
REQ-008 Port: in_data  input  FLIT_WIDTH  upstream flit payload.
REQ-009 Port: in_dest  input  DEST_WIDTH  destination; sampled on the head flit only.
REQ-010 Port: in_last  input  1  marks the final flit of a packet.
REQ-011 Port: data_out  output  FLIT_WIDTH  flit to NoC injection port.
REQ-012 Port: dest_out  output  DEST_WIDTH  destination to NoC.
REQ-013 Port: is_tail_out  output  1  tail marker to NoC.
REQ-014 Port: send_out  output  1  one-cycle pulse per flit injected.
REQ-015 Port: credit_in  input  1  one-cycle pulse; router freed one buffer slot.
REQ-016 Port: credit_count  output  CW=$clog2(FLIT_BUFFER_DEPTH+1)  current credits held.
REQ-017 Port: credit_err  output  1  sticky; credit returned while count already equals FLIT_BUFFER_DEPTH.

Function
REQ-018 in_ready SHALL equal (credit_count != 0), derived from registered state only; no combinational path from credit_in or in_valid.
REQ-019 Accept = in_valid & in_ready; on accept, data_out, is_tail_out (= in_last) and dest_out SHALL register, and send_out SHALL be 1 in the next cycle (latency 1).
REQ-020 send_out SHALL be 0 in any cycle not following an accept; data_out, dest_out, is_tail_out SHALL hold their last values when no accept occurs.
REQ-021 Packet FSM states: IDLE, IN_PKT; IDLE -> IN_PKT on accept with in_last=0; IN_PKT -> IDLE on accept with in_last=1; otherwise hold.
REQ-022 Accept in IDLE SHALL latch in_dest into the packet destination register and drive dest_out = in_dest.
REQ-023 Accept in IN_PKT SHALL drive dest_out = latched destination, ignoring in_dest.
REQ-024 Single-flit packet (accept in IDLE with in_last=1) SHALL stay in IDLE with is_tail_out=1.
REQ-025 Credit update per cycle: accept only -> count-1; credit_in only -> count+1; both -> unchanged; neither -> unchanged.
REQ-026 credit_in when count == FLIT_BUFFER_DEPTH and no accept SHALL leave count saturated and set credit_err to 1 until reset.
REQ-027 Accept SHALL never occur with count 0; the count SHALL never underflow.
REQ-028 A credit returned in cycle t SHALL raise in_ready no earlier than cycle t+1.
REQ-029 Back-to-back accepts SHALL be supported: sustained throughput of 1 flit/cycle while credits remain.

Reset
REQ-030 While rst_n=0 at a clock edge: credit_count=FLIT_BUFFER_DEPTH, FSM=IDLE, send_out=0, is_tail_out=0, data_out=0, dest_out=0, latched destination=0, credit_err=0.
REQ-031 in_ready SHALL be 0 in any cycle where rst_n=0.
REQ-032 Reset asserted mid-packet SHALL abandon the packet; after release the next accepted flit is treated as a head flit.
REQ-033 credit_in pulses in reset cycles SHALL be ignored.

Verification
REQ-034 Reset release, DEPTH=2, in_valid held 1, no credits -> 2 consecutive send_out pulses; in_ready=0 from the cycle after the second accept; credit_count=0.
REQ-035 Count 0, single credit_in pulse at cycle t -> in_ready=1 at t+1; one flit accepted; send_out at t+2; count returns to 0.
REQ-036 4-flit packet, head in_dest=3, body/tail in_dest=7, credits returned every cycle -> dest_out=3 on all 4 flits; is_tail_out=1 only on flit 4; FSM back in IDLE.
REQ-037 Count 1, accept and credit_in in the same cycle -> count stays 1; next flit accepted in the following cycle.
REQ-038 Count=DEPTH=2, extra credit_in -> count stays 2; credit_err=1 and holds until rst_n=0.
REQ-039 Reset asserted after flit 2 of a 4-flit packet, then single-flit packet with in_dest=5 -> dest_out=5, is_tail_out=1, count=DEPTH-1.

Source files
------------

// File: rtl/noc_credit_tx_if.sv
// noc_credit_tx_if
//   Bundles the upstream flit handshake, the NoC injection outputs and the
//   credit return path of the credit-based NoC transmitter.
//
//   Handshake: a flit moves from upstream into the block in any cycle where
//   in_valid and in_ready are both 1. The upstream side may raise in_valid
//   at any time and must hold in_data/in_dest/in_last stable until that
//   cycle. in_ready never depends on in_valid. send_out is a one-cycle
//   pulse per injected flit, with no back-pressure from the NoC; the router
//   returns buffer slots as one-cycle credit_in pulses.
//
//   Modports:
//     master : upstream/NoC environment (drives flits and credits)
//     slave  : the transmitter block
interface noc_credit_tx_if #(
  parameter int FLIT_WIDTH        = 256,
  parameter int DEST_WIDTH        = 4,
  parameter int FLIT_BUFFER_DEPTH = 2,
  localparam int CW               = $clog2(FLIT_BUFFER_DEPTH + 1)
);
  logic                  in_valid;
  logic                  in_ready;
  logic [FLIT_WIDTH-1:0] in_data;
  logic [DEST_WIDTH-1:0] in_dest;
  logic                  in_last;
  logic [FLIT_WIDTH-1:0] data_out;
  logic [DEST_WIDTH-1:0] dest_out;
  logic                  is_tail_out;
  logic                  send_out;
  logic                  credit_in;
  logic [CW-1:0]         credit_count;
  logic                  credit_err;

  modport master (
    output in_valid, in_data, in_dest, in_last, credit_in,
    input  in_ready, data_out, dest_out, is_tail_out, send_out,
           credit_count, credit_err
  );

  modport slave (
    input  in_valid, in_data, in_dest, in_last, credit_in,
    output in_ready, data_out, dest_out, is_tail_out, send_out,
           credit_count, credit_err
  );
endinterface

// File: rtl/noc_credit_tx.sv
// noc_credit_tx
//   Credit-based flit transmitter into a NoC injection port. Holds one
//   credit per free slot of the downstream router input buffer, accepts an
//   upstream flit only while a credit is held, and registers the flit onto
//   the injection port with one cycle of latency. A two-state packet FSM
//   makes the head flit's destination apply to the whole packet.
//
//   Ports:
//     clk           : single clock, rising edge
//     rst_n         : synchronous active-low reset
//     bus           : noc_credit_tx_if.slave (flit handshake, NoC outputs,
//                     credit return, credit count, sticky credit error)
//     pkt_state_dbg : packet FSM state (0 = IDLE, 1 = IN_PKT)
module noc_credit_tx #(
  parameter int FLIT_WIDTH        = 256,
  parameter int DEST_WIDTH        = 4,
  parameter int FLIT_BUFFER_DEPTH = 2,
  localparam int CW               = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  noc_credit_tx_if.slave    bus,
  output logic              pkt_state_dbg
);

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } pkt_state_e;

  localparam logic [CW-1:0] DEPTH_C = CW'(FLIT_BUFFER_DEPTH);

  pkt_state_e            state;
  logic [CW-1:0]         credit_q;
  logic [DEST_WIDTH-1:0] pkt_dest_q;
  logic [FLIT_WIDTH-1:0] data_q;
  logic [DEST_WIDTH-1:0] dest_q;
  logic                  tail_q;
  logic                  send_q;
  logic                  err_q;
  logic                  accept;

  // Ready comes only from the registered credit count (plus reset), so a
  // returned credit is visible one cycle after its pulse and there is no
  // path from credit_in or in_valid.
  assign bus.in_ready = rst_n & (credit_q != '0);
  assign accept       = bus.in_valid & bus.in_ready;

  assign bus.data_out     = data_q;
  assign bus.dest_out     = dest_q;
  assign bus.is_tail_out  = tail_q;
  assign bus.send_out     = send_q;
  assign bus.credit_count = credit_q;
  assign bus.credit_err   = err_q;
  assign pkt_state_dbg    = (state == IN_PKT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      credit_q   <= DEPTH_C;
      pkt_dest_q <= '0;
      data_q     <= '0;
      dest_q     <= '0;
      tail_q     <= 1'b0;
      send_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      send_q <= accept;

      if (accept) begin
        data_q <= bus.in_data;
        tail_q <= bus.in_last;
        // Head flit sets the packet destination; later flits reuse it.
        if (state == IDLE) begin
          dest_q     <= bus.in_dest;
          pkt_dest_q <= bus.in_dest;
        end else begin
          dest_q <= pkt_dest_q;
        end
        state <= bus.in_last ? IDLE : IN_PKT;
      end

      // Accept is impossible at zero credits, so the decrement cannot wrap.
      // A surplus credit with no simultaneous accept is a protocol error.
      unique case ({accept, bus.credit_in})
        2'b10: credit_q <= credit_q - 1'b1;
        2'b01: begin
          if (credit_q == DEPTH_C) err_q <= 1'b1;
          else                     credit_q <= credit_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_credit_tx.sv
module tb_noc_credit_tx;

  localparam int FW = 64;
  localparam int DW = 4;
  localparam int DEPTH = 2;

  logic clk;
  logic rst_n;
  logic pkt_state_dbg;

  int cmp_cnt = 0;
  int err_cnt = 0;

  noc_credit_tx_if #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW), .FLIT_BUFFER_DEPTH(DEPTH)) bus ();

  noc_credit_tx #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW), .FLIT_BUFFER_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .pkt_state_dbg (pkt_state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation vector: {in_ready, send_out, is_tail_out, dest_out[3:0],
  // credit_count[1:0], credit_err, pkt_state}
  logic [10:0] obs;
  assign obs = {bus.in_ready, bus.send_out, bus.is_tail_out, bus.dest_out,
                bus.credit_count, bus.credit_err, pkt_state_dbg};

  // Advance one clock and land 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [FW-1:0] d, input logic [DW-1:0] dst,
                       input logic last, input logic cr);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_dest   = dst;
    bus.in_last   = last;
    bus.credit_in = cr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 64'hdead, 4'd9, 1'b0, 1'b1);
    tick();
    tick();
    cmp_cnt++;
    if (obs !== {1'b0, 1'b0, 1'b0, 4'd0, 2'd2, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL reset_state obs=%b exp=%b", obs, {1'b0, 1'b0, 1'b0, 4'd0, 2'd2, 1'b0, 1'b0});
    end
    cmp_cnt++;
    if (bus.data_out !== 64'd0) begin
      err_cnt++;
      $display("FAIL reset_data got=%h exp=0", bus.data_out);
    end
  endtask

  task automatic test_back_to_back();
    rst_n = 1'b1;
    drive(1'b1, 64'ha1, 4'd1, 1'b0, 1'b0);
    #1;
    cmp_cnt++;
    if (obs !== {1'b1, 1'b0, 1'b0, 4'd0, 2'd2, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL b2b_pre obs=%b exp=%b", obs, {1'b1, 1'b0, 1'b0, 4'd0, 2'd2, 1'b0, 1'b0});
    end
    tick();
    cmp_cnt++;
    if (obs !== {1'b1, 1'b1, 1'b0, 4'd1, 2'd1, 1'b0, 1'b1} || bus.data_out !== 64'ha1) begin
      err_cnt++;
      $display("FAIL b2b_flit1 obs=%b exp=%b data=%h exp=a1", obs, {1'b1, 1'b1, 1'b0, 4'd1, 2'd1, 1'b0, 1'b1}, bus.data_out);
    end
    drive(1'b1, 64'hb2, 4'd9, 1'b1, 1'b0);
    tick();
    cmp_cnt++;
    if (obs !== {1'b0, 1'b1, 1'b1, 4'd1, 2'd0, 1'b0, 1'b0} || bus.data_out !== 64'hb2) begin
      err_cnt++;
      $display("FAIL b2b_flit2 obs=%b exp=%b data=%h exp=b2", obs, {1'b0, 1'b1, 1'b1, 4'd1, 2'd0, 1'b0, 1'b0}, bus.data_out);
    end
    tick();
    cmp_cnt++;
    if (obs !== {1'b0, 1'b0, 1'b1, 4'd1, 2'd0, 1'b0, 1'b0} || bus.data_out !== 64'hb2) begin
      err_cnt++;
      $display("FAIL b2b_stall obs=%b exp=%b data=%h exp=b2", obs, {1'b0, 1'b0, 1'b1, 4'd1, 2'd0, 1'b0, 1'b0}, bus.data_out);
    end
  endtask

  task automatic test_credit_return();
    drive(1'b1, 64'hc3, 4'd2, 1'b1, 1'b1);
    tick();
    cmp_cnt++;
    if (obs !== {1'b1, 1'b0, 1'b1, 4'd1, 2'd1, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL credit_t1 obs=%b exp=%b", obs, {1'b1, 1'b0, 1'b1, 4'd1, 2'd1, 1'b0, 1'b0});
    end
    bus.credit_in = 1'b0;
    tick();
    cmp_cnt++;
    if (obs !== {1'b0, 1'b1, 1'b1, 4'd2, 2'd0, 1'b0, 1'b0} || bus.data_out !== 64'hc3) begin
      err_cnt++;
      $display("FAIL credit_t2 obs=%b exp=%b data=%h exp=c3", obs, {1'b0, 1'b1, 1'b1, 4'd2, 2'd0, 1'b0, 1'b0}, bus.data_out);
    end
    tick();
    cmp_cnt++;
    if (obs !== {1'b0, 1'b0, 1'b1, 4'd2, 2'd0, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL credit_t3 obs=%b exp=%b", obs, {1'b0, 1'b0, 1'b1, 4'd2, 2'd0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_packet();
    logic [10:0] exp;
    drive(1'b0, 64'd0, 4'd0, 1'b0, 1'b1);
    tick();
    cmp_cnt++;
    if (obs !== {1'b1, 1'b0, 1'b1, 4'd2, 2'd1, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL pkt_prime obs=%b exp=%b", obs, {1'b1, 1'b0, 1'b1, 4'd2, 2'd1, 1'b0, 1'b0});
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'(100 + i), (i == 0) ? 4'd3 : 4'd7, (i == 3), 1'b1);
      tick();
      exp = {1'b1, 1'b1, (i == 3), 4'd3, 2'd1, 1'b0, (i != 3)};
      cmp_cnt++;
      if (obs !== exp || bus.data_out !== 64'(100 + i)) begin
        err_cnt++;
        $display("FAIL pkt_flit%0d obs=%b exp=%b data=%0d exp=%0d", i, obs, exp, bus.data_out, 100 + i);
      end
    end
    drive(1'b0, 64'd0, 4'd0, 1'b0, 1'b0);
    tick();
    cmp_cnt++;
    if (obs !== {1'b1, 1'b0, 1'b1, 4'd3, 2'd1, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL pkt_idle obs=%b exp=%b", obs, {1'b1, 1'b0, 1'b1, 4'd3, 2'd1, 1'b0, 1'b0});
    end
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 64'he5, 4'd4, 1'b1, 1'b1);
    tick();
    cmp_cnt++;
    if (obs !== {1'b1, 1'b1, 1'b1, 4'd4, 2'd1, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL sim_both obs=%b exp=%b", obs, {1'b1, 1'b1, 1'b1, 4'd4, 2'd1, 1'b0, 1'b0});
    end
    drive(1'b1, 64'hf6, 4'd4, 1'b1, 1'b0);
    tick();
    cmp_cnt++;
    if (obs !== {1'b0, 1'b1, 1'b1, 4'd4, 2'd0, 1'b0, 1'b0} || bus.data_out !== 64'hf6) begin
      err_cnt++;
      $display("FAIL sim_next obs=%b exp=%b data=%h exp=f6", obs, {1'b0, 1'b1, 1'b1, 4'd4, 2'd0, 1'b0, 1'b0}, bus.data_out);
    end
    drive(1'b0, 64'd0, 4'd0, 1'b0, 1'b0);
    tick();
    cmp_cnt++;
    if (obs !== {1'b0, 1'b0, 1'b1, 4'd4, 2'd0, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL sim_idle obs=%b exp=%b", obs, {1'b0, 1'b0, 1'b1, 4'd4, 2'd0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_overflow();
    logic [10:0] exp;
    bus.credit_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = {1'b1, 1'b0, 1'b1, 4'd4, (i == 0) ? 2'd1 : 2'd2, (i == 2), 1'b0};
      cmp_cnt++;
      if (obs !== exp) begin
        err_cnt++;
        $display("FAIL ovf_credit%0d obs=%b exp=%b", i, obs, exp);
      end
    end
    bus.credit_in = 1'b0;
    tick();
    cmp_cnt++;
    if (obs !== {1'b1, 1'b0, 1'b1, 4'd4, 2'd2, 1'b1, 1'b0}) begin
      err_cnt++;
      $display("FAIL ovf_sticky obs=%b exp=%b", obs, {1'b1, 1'b0, 1'b1, 4'd4, 2'd2, 1'b1, 1'b0});
    end
    rst_n = 1'b0;
    tick();
    cmp_cnt++;
    if (obs !== {1'b0, 1'b0, 1'b0, 4'd0, 2'd2, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL ovf_cleared obs=%b exp=%b", obs, {1'b0, 1'b0, 1'b0, 4'd0, 2'd2, 1'b0, 1'b0});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 64'h71, 4'd6, 1'b0, 1'b0);
    tick();
    cmp_cnt++;
    if (obs !== {1'b1, 1'b1, 1'b0, 4'd6, 2'd1, 1'b0, 1'b1}) begin
      err_cnt++;
      $display("FAIL mrst_flit1 obs=%b exp=%b", obs, {1'b1, 1'b1, 1'b0, 4'd6, 2'd1, 1'b0, 1'b1});
    end
    drive(1'b1, 64'h72, 4'd7, 1'b0, 1'b0);
    tick();
    cmp_cnt++;
    if (obs !== {1'b0, 1'b1, 1'b0, 4'd6, 2'd0, 1'b0, 1'b1}) begin
      err_cnt++;
      $display("FAIL mrst_flit2 obs=%b exp=%b", obs, {1'b0, 1'b1, 1'b0, 4'd6, 2'd0, 1'b0, 1'b1});
    end
    rst_n = 1'b0;
    tick();
    cmp_cnt++;
    if (obs !== {1'b0, 1'b0, 1'b0, 4'd0, 2'd2, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL mrst_reset obs=%b exp=%b", obs, {1'b0, 1'b0, 1'b0, 4'd0, 2'd2, 1'b0, 1'b0});
    end
    rst_n = 1'b1;
    drive(1'b1, 64'h55, 4'd5, 1'b1, 1'b0);
    tick();
    cmp_cnt++;
    if (obs !== {1'b1, 1'b1, 1'b1, 4'd5, 2'd1, 1'b0, 1'b0} || bus.data_out !== 64'h55) begin
      err_cnt++;
      $display("FAIL mrst_single obs=%b exp=%b data=%h exp=55", obs, {1'b1, 1'b1, 1'b1, 4'd5, 2'd1, 1'b0, 1'b0}, bus.data_out);
    end
    drive(1'b0, 64'd0, 4'd0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 64'd0, 4'd0, 1'b0, 1'b0);
    test_reset();
    test_back_to_back();
    test_credit_return();
    test_packet();
    test_simultaneous();
    test_overflow();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
